// File: rtl/stage_ex_pkg.sv
// Shared definitions for the execute stage: operator codes, divider state
// encoding and the divider step count.
package cpu_defines;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_XOR   = 5'd3;
    localparam logic [4:0] OP_NOR   = 5'd4;
    localparam logic [4:0] OP_ADD   = 5'd5;
    localparam logic [4:0] OP_SUB   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLTU  = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRL   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_MULTU = 5'd13;
    localparam logic [4:0] OP_DIV   = 5'd14;
    localparam logic [4:0] OP_DIVU  = 5'd15;
    localparam logic [4:0] OP_MFHI  = 5'd16;
    localparam logic [4:0] OP_MFLO  = 5'd17;
    localparam logic [4:0] OP_MTHI  = 5'd18;
    localparam logic [4:0] OP_MTLO  = 5'd19;

    localparam logic [1:0] DIV_IDLE   = 2'd0;
    localparam logic [1:0] DIV_DIVIDE = 2'd1;
    localparam logic [1:0] DIV_DONE   = 2'd2;

    localparam int DIVIDE_STEPS = 32;

    // True for either division flavour.
    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/stage_ex_divider.sv
// Iterative restoring divider: one quotient bit per cycle, signs applied
// in the DONE state so quotient/remainder are final while done is high.
module stage_ex_divider
    import cpu_defines::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] LAST_STEP = 5'(DIVIDE_STEPS - 1);

    logic [1:0]  state;
    logic [4:0]  counter;
    logic [63:0] work;          // {partial remainder, quotient / shifting dividend}
    logic [31:0] divisor_q;
    logic        quotient_neg;
    logic        remainder_neg;

    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [32:0] remainder_shift;
    logic [33:0] trial;
    logic [63:0] work_next;

    // Operand magnitudes and one restoring step on the current work register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dividend_mag    = dividend;
        divisor_mag     = divisor;
        if (is_signed && dividend[31]) dividend_mag = -dividend;
        if (is_signed && divisor[31])  divisor_mag  = -divisor;

        remainder_shift = {work[63:32], work[31]};
        trial           = {1'b0, remainder_shift} - {2'b00, divisor_q};
        if (trial[33])
            work_next = {remainder_shift[31:0], work[30:0], 1'b0};
        else
            work_next = {trial[31:0], work[30:0], 1'b1};
    end

    // Divider FSM: load in IDLE, 32 steps in DIVIDE, one result cycle in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: datapath registers are reset too so a discarded division leaves no stale state.
            state         <= DIV_IDLE;
            counter       <= '0;
            work          <= '0;
            divisor_q     <= '0;
            quotient_neg  <= 1'b0;
            remainder_neg <= 1'b0;
        end else if (cancel) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state   <= DIV_IDLE;
            counter <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        counter <= '0;
                        if (divisor == 32'd0) begin
                            work          <= {dividend, 32'hFFFF_FFFF};
                            quotient_neg  <= 1'b0;
                            remainder_neg <= 1'b0;
                            state         <= DIV_DONE;
                        end else begin
                            work          <= {32'd0, dividend_mag};
                            divisor_q     <= divisor_mag;
                            quotient_neg  <= is_signed && (dividend[31] ^ divisor[31]);
                            remainder_neg <= is_signed && dividend[31];
                            state         <= DIV_DIVIDE;
                        end
                    end
                end
                DIV_DIVIDE: begin
                    work    <= work_next;
                    counter <= counter + 5'd1;
                    if (counter == LAST_STEP) state <= DIV_DONE;
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = !cancel && (((state == DIV_IDLE) && start) || (state == DIV_DIVIDE));
    assign done      = (state == DIV_DONE);
    assign quotient  = quotient_neg  ? -work[31:0]  : work[31:0];
    assign remainder = remainder_neg ? -work[63:32] : work[63:32];

endmodule

// File: rtl/stage_ex.sv
// MIPS execute stage: single-cycle ALU and multiply, HI/LO ownership, and
// pipeline stall while the iterative divider is running.
module stage_ex
    import cpu_defines::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  operator_,
    input  logic [31:0] operand_a_,
    input  logic [31:0] operand_b_,
    input  logic        register_write_enable_,
    input  logic [4:0]  register_write_address_,
    input  logic        cancel,
    output logic        register_write_enable,
    output logic [4:0]  register_write_address,
    output logic [31:0] register_write_data,
    output logic        stall_request
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_result;
    logic [63:0] product_signed;
    logic [63:0] product_unsigned;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    stage_ex_divider u_divider (
        .clock     (clock),
        .reset     (reset),
        .start     (is_div_op(operator_)),
        .is_signed (operator_ == OP_DIV),
        .cancel    (cancel),
        .dividend  (operand_a_),
        .divisor   (operand_b_),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    assign product_signed   = {{32{operand_a_[31]}}, operand_a_} * {{32{operand_b_[31]}}, operand_b_};
    assign product_unsigned = {32'd0, operand_a_} * {32'd0, operand_b_};

    // ALU / move-from result selection.
    always_comb begin
        alu_result = 32'd0;
        case (operator_)
            OP_OR:   alu_result = operand_a_ | operand_b_;
            OP_AND:  alu_result = operand_a_ & operand_b_;
            OP_XOR:  alu_result = operand_a_ ^ operand_b_;
            OP_NOR:  alu_result = ~(operand_a_ | operand_b_);
            OP_ADD:  alu_result = operand_a_ + operand_b_;
            OP_SUB:  alu_result = operand_a_ - operand_b_;
            OP_SLT:  alu_result = {31'd0, $signed(operand_a_) < $signed(operand_b_)};
            OP_SLTU: alu_result = {31'd0, operand_a_ < operand_b_};
            OP_SLL:  alu_result = operand_b_ << operand_a_[4:0];
            OP_SRL:  alu_result = operand_b_ >> operand_a_[4:0];
            OP_SRA:  alu_result = $signed(operand_b_) >>> operand_a_[4:0];
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            default: alu_result = 32'd0;
        endcase
    end

    // HI/LO update from multiply, move-to and the divider result cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (!cancel) begin
            if (div_done) begin
                hi <= div_remainder;
                lo <= div_quotient;
            end else begin
                case (operator_)
                    OP_MULT:  {hi, lo} <= product_signed;
                    OP_MULTU: {hi, lo} <= product_unsigned;
                    OP_MTHI:  hi <= operand_a_;
                    OP_MTLO:  lo <= operand_a_;
                    default:  ;
                endcase
            end
        end
    end

    // Outputs are forced to zero while reset is asserted.
    assign stall_request          = !reset && div_busy;
    assign register_write_enable  = !reset && register_write_enable_ && !div_busy && !cancel;
    assign register_write_address = reset ? 5'd0  : register_write_address_;
    assign register_write_data    = reset ? 32'd0 : alu_result;

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: stimulus pushes expected register writes into
// a scoreboard queue, a negedge monitor pops and compares each DUT write.
module tb_stage_ex;
    import cpu_defines::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  operator_ = OP_DIV;
    logic [31:0] operand_a_ = 32'd9;
    logic [31:0] operand_b_ = 32'd2;
    logic        register_write_enable_ = 1'b1;
    logic [4:0]  register_write_address_ = 5'd5;
    logic        cancel = 1'b0;
    logic        register_write_enable;
    logic [4:0]  register_write_address;
    logic [31:0] register_write_data;
    logic        stall_request;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t scoreboard[$];
    int   checks = 0;
    int   passes = 0;

    stage_ex dut (
        .clock                   (clock),
        .reset                   (reset),
        .operator_               (operator_),
        .operand_a_              (operand_a_),
        .operand_b_              (operand_b_),
        .register_write_enable_  (register_write_enable_),
        .register_write_address_ (register_write_address_),
        .cancel                  (cancel),
        .register_write_enable   (register_write_enable),
        .register_write_address  (register_write_address),
        .register_write_data     (register_write_data),
        .stall_request           (stall_request)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Monitor: every DUT register write must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && register_write_enable === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         register_write_address, register_write_data);
            end else begin
                exp_t e;
                e = scoreboard.pop_front();
                check({e.name, "_addr"}, 32'(register_write_address), 32'(e.addr));
                check(e.name, register_write_data, e.data);
            end
        end
    end

    // Present one instruction for one cycle; queue its write if one is expected.
    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic we, input logic [4:0] addr,
                         input logic [31:0] exp_data);
        if (we && !cancel) scoreboard.push_back('{name, addr, exp_data});
        operator_               = op;
        operand_a_              = a;
        operand_b_              = b;
        register_write_enable_  = we;
        register_write_address_ = addr;
        @(posedge clock); #1;
    endtask

    // Present a division, count stall cycles and check write masking while stalled.
    task automatic run_div(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic we, input logic [4:0] addr,
                           input int exp_stalls);
        int stalls;
        int leaks;
        stalls = 0;
        leaks  = 0;
        if (we) scoreboard.push_back('{{name, "_done_write"}, addr, 32'd0});
        operator_               = op;
        operand_a_              = a;
        operand_b_              = b;
        register_write_enable_  = we;
        register_write_address_ = addr;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (stall_request !== 1'b1) break;
            stalls++;
            if (register_write_enable !== 1'b0) leaks++;
        end
        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        check({name, "_masked_writes"}, 32'(leaks), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        // Reset state, with a DIV presented to prove outputs are forced low.
        #2;
        check("reset_stall", 32'(stall_request), 32'd0);
        check("reset_we", 32'(register_write_enable), 32'd0);
        check("reset_addr", 32'(register_write_address), 32'd0);
        check("reset_data", register_write_data, 32'd0);
        operator_ = OP_NOP;
        register_write_enable_ = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;

        issue("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'd1,         1'b1, 5'd3,  32'h8000_0000);
        issue("add_nowe", OP_ADD,  32'd1,         32'd2,         1'b0, 5'd3,  32'd0);
        issue("slt_neg",  OP_SLT,  32'hFFFF_FFFF, 32'd1,         1'b1, 5'd4,  32'd1);
        issue("sltu_neg", OP_SLTU, 32'hFFFF_FFFF, 32'd1,         1'b1, 5'd5,  32'd0);
        issue("sra",      OP_SRA,  32'd4,         32'h8000_0000, 1'b1, 5'd6,  32'hF800_0000);
        issue("srl",      OP_SRL,  32'd4,         32'h8000_0000, 1'b1, 5'd7,  32'h0800_0000);
        issue("sll31",    OP_SLL,  32'd31,        32'd1,         1'b1, 5'd8,  32'h8000_0000);
        issue("sub_wrap", OP_SUB,  32'd0,         32'd1,         1'b1, 5'd9,  32'hFFFF_FFFF);
        issue("nor",      OP_NOR,  32'h0F0F_0000, 32'h0000_00F0, 1'b1, 5'd10, 32'hF0F0_FF0F);
        issue("xor",      OP_XOR,  32'hFFFF_0000, 32'h0FF0_0FF0, 1'b1, 5'd11, 32'hF00F_0FF0);

        // Signed multiply, then read the product back.
        issue("mult",     OP_MULT, 32'hFFFF_FFFE, 32'd3,         1'b0, 5'd0,  32'd0);
        issue("mult_hi",  OP_MFHI, 32'd0,         32'd0,         1'b1, 5'd12, 32'hFFFF_FFFF);
        issue("mult_lo",  OP_MFLO, 32'd0,         32'd0,         1'b1, 5'd13, 32'hFFFF_FFFA);
        issue("multu",    OP_MULTU,32'hFFFF_FFFF, 32'd2,         1'b0, 5'd0,  32'd0);
        issue("multu_hi", OP_MFHI, 32'd0,         32'd0,         1'b1, 5'd12, 32'h0000_0001);
        issue("multu_lo", OP_MFLO, 32'd0,         32'd0,         1'b1, 5'd13, 32'hFFFF_FFFE);

        // Divisions.
        run_div("divu_7_2", OP_DIVU, 32'd7, 32'd2, 1'b0, 5'd0, 33);
        issue("divu_hi",  OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd14, 32'd1);
        issue("divu_lo",  OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd15, 32'd3);
        run_div("div_5_0", OP_DIV, 32'd5, 32'd0, 1'b0, 5'd0, 1);
        issue("div0_hi",  OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd14, 32'd5);
        issue("div0_lo",  OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd15, 32'hFFFF_FFFF);
        // Write enable requested during the stall only reaches the output in DONE.
        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b1, 5'd16, 33);
        // Back-to-back: accepted straight after the previous DONE.
        run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd0, 33);
        issue("div_hi",   OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd17, 32'hFFFF_FFFF);
        issue("div_lo",   OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd18, 32'hFFFF_FFFD);

        // Cancel: masks writes, blocks HI/LO updates, aborts a division.
        issue("mthi",     OP_MTHI, 32'h0000_AAAA, 32'd0, 1'b0, 5'd0, 32'd0);
        issue("mtlo",     OP_MTLO, 32'h0000_BBBB, 32'd0, 1'b0, 5'd0, 32'd0);
        cancel = 1'b1;
        issue("add_cancel", OP_ADD, 32'd1, 32'd1, 1'b1, 5'd19, 32'd2);
        issue("mthi_cancel", OP_MTHI, 32'h0000_DEAD, 32'd0, 1'b0, 5'd0, 32'd0);
        cancel = 1'b0;
        operator_               = OP_DIV;
        operand_a_              = 32'd100;
        operand_b_              = 32'd3;
        register_write_enable_  = 1'b1;
        register_write_address_ = 5'd20;
        repeat (10) @(posedge clock);
        #1;
        cancel = 1'b1;
        @(negedge clock);
        check("cancel_stall", 32'(stall_request), 32'd0);
        check("cancel_we", 32'(register_write_enable), 32'd0);
        @(posedge clock); #1;
        cancel = 1'b0;
        issue("mtlo_after", OP_MTLO, 32'h0000_1234, 32'd0, 1'b0, 5'd0, 32'd0);
        issue("cancel_hi",  OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd21, 32'h0000_AAAA);
        issue("cancel_lo",  OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd22, 32'h0000_1234);

        // Asynchronous reset in the middle of a division.
        issue("mthi_5", OP_MTHI, 32'd5, 32'd0, 1'b0, 5'd0, 32'd0);
        operator_               = OP_DIV;
        operand_a_              = 32'd100;
        operand_b_              = 32'd3;
        register_write_enable_  = 1'b1;
        register_write_address_ = 5'd7;
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_stall", 32'(stall_request), 32'd0);
        check("midreset_we", 32'(register_write_enable), 32'd0);
        check("midreset_addr", 32'(register_write_address), 32'd0);
        check("midreset_data", register_write_data, 32'd0);
        @(posedge clock); #1;
        operator_ = OP_NOP;
        register_write_enable_ = 1'b0;
        reset = 1'b0;
        issue("reset_hi", OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd23, 32'd0);
        issue("reset_lo", OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd24, 32'd0);
        issue("tail_nop", OP_NOP, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        @(negedge clock);
        check("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stage_ex.md
# stage_ex

Execute stage of the five-stage MIPS pipeline. It sits between the ID/EX pipeline register and the MEM stage, and produces the register-write triple (enable, address, data) that the EX/MEM register passes to MEM. It performs single-cycle ALU and multiply operations and owns the HI/LO registers. Signed and unsigned division run on an iterative 32-cycle divider, and the stage holds the pipeline via `stall_request` while a division is in progress.

## Interface
- No parameters. Opcode widths and values come from the shared package.
- `clock` input 1: the single clock.
- `reset` input 1: asynchronous, active-high.
- `operator_` input 5: operation code from ID/EX.
- `operand_a_` input 32: rs value; also supplies the shift amount in bits [4:0].
- `operand_b_` input 32: rt value or immediate.
- `register_write_enable_` input 1: GPR write request from ID/EX.
- `register_write_address_` input 5: destination GPR.
- `cancel` input 1: pipeline flush; aborts the instruction currently in EX.
- `register_write_enable` output 1: toward EX/MEM.
- `register_write_address` output 5: toward EX/MEM.
- `register_write_data` output 32: toward EX/MEM.
- `stall_request` output 1: high means ID/EX and earlier stages must hold.

## Operation
- Operations: OR, AND, XOR, NOR, ADD, SUB (wrap-around, no overflow trap), SLT (signed), SLTU, SLL, SRL, SRA (shift `operand_b_` by `operand_a_[4:0]`), MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, NOP.
- ALU and MF* results drive `register_write_data` combinationally.
- `register_write_enable` = `register_write_enable_` && !`stall_request` && !`cancel`.
- MULT/MULTU: full 64-bit product; HI := [63:32], LO := [31:0] on the clock edge that ends the cycle.
- MTHI/MTLO write HI or LO on that same edge.
- HI/LO are never written when `cancel` is high.
- Divider FSM states:
  - IDLE: on DIV/DIVU with `cancel` low and `operand_b_` != 0 → load the magnitudes (signed) or raw values (unsigned), record the result signs, counter := 0, go to DIVIDE. If `operand_b_` == 0 → go to DONE with quotient = 0xFFFFFFFF and remainder = `operand_a_`.
  - DIVIDE: one restoring step per cycle (shift the remainder left, trial subtract, shift in a quotient bit); after counter reaches 31 → DONE.
  - DONE: apply signs (quotient negated if the operand signs differ; remainder takes the dividend's sign); HI := remainder, LO := quotient; go to IDLE.
- `stall_request` is high in IDLE when a DIV/DIVU is presented, and throughout DIVIDE. It is low in DONE.
- `cancel` in any state: FSM → IDLE next edge, HI/LO untouched, `stall_request` low in that cycle.
- Upstream holds `operator_` and the operands stable while `stall_request` is high.
- Reset: all outputs 0, HI = LO = 0, FSM IDLE, counter 0. Reset asserted mid-division discards it.

## Timing
- ALU, MUL and MF*/MT* ops have a single-cycle result; HI/LO are visible to an MFHI/MFLO in the next cycle. No HI/LO forwarding is needed because HI/LO are written in EX.
- DIV with a nonzero divisor presented in cycle 0:
  - `stall_request` is high in cycles 0–32 (33 cycles).
  - Cycle 33 is DONE with stall low; HI/LO are updated at the end of cycle 33.
  - The next instruction enters EX in cycle 34.
- Divide by zero: stall is high in cycle 0 only, DONE in cycle 1, HI/LO written at the end of cycle 1.
- Back-to-back DIVs: the second DIV is accepted in IDLE on the cycle after DONE.

## Structure
- The shared package `cpu_defines` holds:
  - the 5-bit operator codes;
  - the divider state encoding (IDLE / DIVIDE / DONE);
  - the constant `DIVIDE_STEPS` = 32.
- Sub-module `stage_ex_divider`: the FSM, counter, and 64-bit remainder/quotient register, with start/signed/cancel inputs and busy/done/quotient/remainder outputs.
- HI/LO and the ALU mux stay in `stage_ex`.

## Test plan
- Basic ALU ops:
  - ADD 0x7FFFFFFF + 1 → data 0x80000000, enable follows input.
  - SLT −1 vs 1 → 1; SLTU −1 vs 1 → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
- MULT then MFHI/MFLO: MULT −2 × 3, then MFHI → 0xFFFFFFFF next cycle, MFLO → 0xFFFFFFFA.
- Signed division: DIV −7 / 2 → stall high for exactly 33 cycles; HI = 0xFFFFFFFF (−1), LO = 0xFFFFFFFD (−3). DIVU 7 / 2 → HI = 1, LO = 3.
- Divide by zero: DIV 5 / 0 → stall high for 1 cycle; HI = 5, LO = 0xFFFFFFFF.
- Cancel and reset during division:
  - `cancel` asserted in cycle 10 of a DIV → stall drops that cycle, HI/LO unchanged, a following MTLO 0x1234 commits normally.
  - Async `reset` mid-DIV → all outputs 0 immediately, HI = LO = 0.
- Stall masking: during a DIV stall with `register_write_enable_` = 1 on the inputs → `register_write_enable` stays 0 until DONE.
